logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised successor to the single-bit two-input gate cells: a WIDTH-bit bitwise logic unit with op select.
- Two-stage valid/ready pipeline, result reduction flags and an optional transaction counter.
- Sits between operand source and result sink wherever gate functions are needed on buses with flow control.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of completed-transaction counter (optional feature)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept operand beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  function select, sampled with operands
out_valid  output  1  result beat valid
out_ready  input  1  sink accepts result
y  output  WIDTH  registered result
zero  output  1  y == 0
ones  output  1  y == all ones
parity  output  1  XOR-reduction of y
count  output  CNT_W  completed-transaction count

Behaviour:
- Interface: one clock, clk; reset synchronous active-high, rst; everything sampled on rising clk.
- Op encoding:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR: bitwise on a, b.
  - 6 NOT a; 7 PASS a. b is ignored for ops 6 and 7.
- Stage 1 (S1): registers a, b, op and s1_valid on input handshake (in_valid && in_ready).
- Stage 2 (S2): computes the S1 function; registers y, zero, ones, parity and s2_valid (drives out_valid).
- Flow control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational path from out_ready; documented, accepted).
- Stage transfers:
  - S1 loads when s1_adv; s1_valid <= in_valid.
  - S2 loads when s2_adv; s2_valid <= s1_valid.
  - A stage holds all its registers while its advance signal is low.
- Latency: 2 cycles from accepted input to out_valid, with no backpressure.
- Throughput: 1 beat/cycle while out_ready stays high.
- Output stability: while out_valid && !out_ready, y and the flags hold stable and out_valid stays 1.
- Ordering: no beat is dropped or duplicated; order is preserved.
- Bubble: with in_valid=0 and out_ready=1, valids drain to 0 within 2 cycles.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts a new beat the same cycle one leaves.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, y=0, zero=1, ones=0, parity=0, count=0.
- Reset mid-operation: all in-flight beats are discarded. in_ready=1 during the cycle after reset (pipe empty).
- Flags are registered alongside y; they always describe the y currently presented.
- ones at WIDTH=1: equals y.

Optional Feature:
- Macro: LOGIC_UNIT_PIPE_CNT_EN.
- Defined:
  - count increments by 1 on each output handshake (out_valid && out_ready).
  - Saturates at 2^CNT_W-1; does not wrap.
  - Reset clears it to 0.
- Undefined: count tied to 0; no counter flops synthesised.

Test Plan:
- WIDTH=8, rst high 2 cycles, then low, out_ready=1; a=8'hF0, b=8'hCC, op=2 (NAND) accepted at cycle 0 -> cycle 2: out_valid=1, y=8'h3F, zero=0, ones=0, parity=0.
- Stream ops 0..7 back-to-back with a=8'hAA, b=8'h55, out_ready=1:
  - y sequence: 00, FF, FF, 00, FF, 00, 55, AA.
  - zero=1 on ops 0, 3, 5; ones=1 on ops 1, 2, 4.
  - One result per cycle; in_ready constantly 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats accepted, then in_ready=0; y stable.
  - Release out_ready -> results appear in order with no loss or duplication.
- Reset mid-stream: assert rst with both stages valid -> next cycle out_valid=0, y=0, zero=1, count=0, in_ready=1.
- With LOGIC_UNIT_PIPE_CNT_EN, CNT_W=2: complete 5 handshakes -> count reads 1, 2, 3, 3, 3. Without the macro, count=0 throughout.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT a/PASS a) with result flags.
// Optional saturating completed-transaction counter enabled by defining LOGIC_UNIT_PIPE_CNT_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] count
);

  // Handshake rule: a beat transfers on a rising edge where valid && ready.
  // Each stage advances when it is empty or the stage after it is advancing,
  // so in_ready depends combinationally on out_ready.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] f;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  always_comb begin
    f = '0;
    case (s1_op)
      3'd0:    f = s1_a & s1_b;
      3'd1:    f = s1_a | s1_b;
      3'd2:    f = ~(s1_a & s1_b);
      3'd3:    f = ~(s1_a | s1_b);
      3'd4:    f = s1_a ^ s1_b;
      3'd5:    f = ~(s1_a ^ s1_b);
      3'd6:    f = ~s1_a;
      default: f = s1_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  // y and flags only update with a real beat, so they keep describing the last result after a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y        <= '0;
      zero     <= 1'b1;
      ones     <= 1'b0;
      parity   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y      <= f;
        zero   <= (f == '0);
        ones   <= (f == '1);
        parity <= ^f;
      end
    end
  end

`ifdef LOGIC_UNIT_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (s2_valid && out_ready && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign count = cnt;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: driver pushes expected results, a negedge monitor pops and compares.
// Expected results come from per-bit gate truth tables; count checked against a saturating handshake tally.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;
`ifdef LOGIC_UNIT_PIPE_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ones;
  logic             parity;
  logic [CNT_W-1:0] count;

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ones(ones), .parity(parity), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: {y, zero, ones, parity}
  logic [WIDTH+2:0] exp_q[$];
  int               cyc_q[$];
  bit               exact_q[$];
  int               n_chk = 0;
  int               n_pass = 0;
  int               hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [WIDTH+2:0] pack_y(input logic [WIDTH-1:0] r);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += r[i];
    return {r, (n == 0), (n == WIDTH), n[0]};
  endfunction

  // truth table per op, indexed by {a_bit, b_bit}
  function automatic logic [WIDTH+2:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic [2:0] mop);
    logic [3:0] tt[8];
    logic [WIDTH-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
    for (int i = 0; i < WIDTH; i++) r[i] = tt[mop][{ma[i], mb[i]}];
    return pack_y(r);
  endfunction

  function automatic int exp_count(input int n);
`ifdef LOGIC_UNIT_PIPE_CNT_EN
    int mx;
    mx = (1 << CNT_W) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  // driver: called at posedge+1; use_y selects a literal expected y over the model
  task automatic drive(input logic v, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic [2:0] top, input logic ordy, input bit exact,
                       input bit use_y, input logic [WIDTH-1:0] ey, output bit acc);
    in_valid = v; a = ta; b = tb_v; op = top; out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (exact) chk("in_ready_stream", in_ready, 1);
    if (acc) begin
      exp_q.push_back(use_y ? pack_y(ey) : model(ta, tb_v, top));
      cyc_q.push_back(cyc);
      exact_q.push_back(exact);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0; out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // monitor
  bit               prev_stall = 1'b0;
  logic [WIDTH+2:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); cyc_q.delete(); exact_q.delete();
      hs = 0;
      prev_stall = 1'b0;
    end else begin
      chk("count", 32'(count), exp_count(hs));
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_stable", {y, zero, ones, parity}, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          int lat;
          bit ex;
          chk("result", {y, zero, ones, parity}, exp_q.pop_front());
          lat = cyc - cyc_q.pop_front();
          ex = exact_q.pop_front();
          if (ex) chk("latency", lat, 2);
          else chk("latency_min", (lat >= 2), 1);
        end
        hs++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {y, zero, ones, parity};
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_zero"}, zero, 1);
    chk({tag, "_ones"}, ones, 0);
    chk({tag, "_parity"}, parity, 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    bit acc;
    int nacc;
    logic [WIDTH-1:0] stream_y[8];
    stream_y[0] = 8'h00; stream_y[1] = 8'hFF; stream_y[2] = 8'hFF; stream_y[3] = 8'h00;
    stream_y[4] = 8'hFF; stream_y[5] = 8'h00; stream_y[6] = 8'h55; stream_y[7] = 8'hAA;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // single NAND beat
    drive(1, 8'hF0, 8'hCC, 3'd2, 1, 1, 1, 8'h3F, acc);
    drain();

    // ops 0..7 back to back
    for (int i = 0; i < 8; i++) drive(1, 8'hAA, 8'h55, 3'(i), 1, 1, 1, stream_y[i], acc);
    drain();

    // backpressure: only two beats fit
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(i * 37 + 3), 8'(i * 11), 3'(i), 0, 0, 0, '0, acc);
      nacc += acc;
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", in_ready, 0);
    drain();

    // reset with both stages full
    drive(1, 8'h12, 8'h34, 3'd4, 0, 0, 0, '0, acc);
    drive(1, 8'h56, 8'h78, 3'd1, 0, 0, 0, '0, acc);
    chk("mid_full", out_valid, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("mid_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_out_valid", out_valid, 0);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) != 0), 0, 0, '0, acc);
    end
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
